// File: rtl/game_tick_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_tick_pkg
// Description : Shared types and helpers for the Bricks game tick generator:
//               run-state encoding, timeout length and speed clamping.
// Revision    : 1.0 - initial release
// ============================================================================
package game_tick_pkg;

    // Run state of the tick generator
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // Seconds of play before the optional timeout ends the round
    localparam int unsigned TIMEOUT_SEC = 60;

    // Limit a requested speed level to the highest supported level
    function automatic int unsigned clamp_speed(input int unsigned req,
                                                input int unsigned max_lvl);
        return (req > max_lvl) ? max_lvl : req;
    endfunction

endpackage
`default_nettype wire

// File: rtl/game_tick_gen_period_counter.sv
`default_nettype none
// ============================================================================
// Module      : period_counter
// Description : Free-running modulo counter. Counts 0..period-1 while en is
//               high and flags the terminal count combinationally so the
//               parent can register its pulse on the same edge as the wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module period_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] period,
    output logic             wrap
);

    logic [CNT_W-1:0] r_count;

    // Terminal count reached on an enabled cycle; a held count never wraps
    assign wrap = en & (r_count == (period - CNT_W'(1)));

    // Count register: clear wins, otherwise advance only when enabled
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= wrap ? '0 : (r_count + CNT_W'(1));
        end
    end

endmodule
`default_nettype wire

// File: rtl/game_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : game_tick_gen
// Description : Game-pace tick generator for Bricks. Produces a speed-
//               selectable tick with a 50% duty toggle, a real-time 1 s
//               pulse and a saturating elapsed-seconds count, with
//               start/restart and pause/resume control.
//               Optional macro GAME_TICK_TIMEOUT_EN adds a sticky timeout
//               output that stops play after TIMEOUT_SEC seconds.
// Revision    : 1.0 - initial release
// ============================================================================
module game_tick_gen
    import game_tick_pkg::*;
#(
    parameter  int CLK_HZ    = 50000000,
    parameter  int MAX_SPEED = 3,
    parameter  int SEC_W     = 8,
    localparam int CNT_W     = $clog2(CLK_HZ + 1),
    localparam int SPD_W     = $clog2(MAX_SPEED + 1)
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             startN,
    input  logic             pause,
    input  logic [SPD_W-1:0] speed,
    output logic             tick,
    output logic             duty50,
    output logic             sec_pulse,
    output logic [SEC_W-1:0] elapsed_sec,
`ifdef GAME_TICK_TIMEOUT_EN
    output logic             timeout,
`endif
    output logic             running
);

    localparam logic [CNT_W-1:0] BASE_PERIOD = CNT_W'(CLK_HZ);
    localparam logic [SEC_W-1:0] SEC_MAX     = '1;

    state_t           state;
    state_t           state_nxt;
    logic [SPD_W-1:0] r_speed;
    logic [CNT_W-1:0] w_tick_period;
    logic             w_restart;
    logic             w_count_en;
    logic             w_clr;
    logic             w_tick_wrap;
    logic             w_sec_wrap;
    logic             w_timeout_hit;

    assign w_restart     = ~startN;
    // Pause in the same cycle as a terminal count freezes the count at P-1
    assign w_count_en    = startN & (state == RUN) & ~pause & ~w_timeout_hit;
    assign w_clr         = w_restart | (state == IDLE);
    assign w_tick_period = BASE_PERIOD >> r_speed;

`ifdef GAME_TICK_TIMEOUT_EN
    assign w_timeout_hit = (state == RUN) && (32'(elapsed_sec) >= TIMEOUT_SEC);

    // Sticky timeout flag, cleared only by restart or reset
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            timeout <= 1'b0;
        end else if (w_restart) begin
            timeout <= 1'b0;
        end else if (w_timeout_hit) begin
            timeout <= 1'b1;
        end
    end
`else
    assign w_timeout_hit = 1'b0;
`endif

    period_counter #(.CNT_W(CNT_W)) u_tick_cnt (
        .clk    (clk),
        .resetN (resetN),
        .clr    (w_clr),
        .en     (w_count_en),
        .period (w_tick_period),
        .wrap   (w_tick_wrap)
    );

    period_counter #(.CNT_W(CNT_W)) u_sec_cnt (
        .clk    (clk),
        .resetN (resetN),
        .clr    (w_clr),
        .en     (w_count_en),
        .period (BASE_PERIOD),
        .wrap   (w_sec_wrap)
    );

    // State register; running is registered alongside it
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state   <= IDLE;
            running <= 1'b0;
        end else begin
            state   <= state_nxt;
            running <= (state_nxt == RUN);
        end
    end

    // Next-state logic: restart overrides everything, then timeout, then pause
    always_comb begin
        state_nxt = state;
        if (w_restart) begin
            state_nxt = RUN;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                RUN: begin
                    if (w_timeout_hit) begin
                        state_nxt = IDLE;
                    end else if (pause) begin
                        state_nxt = PAUSE;
                    end
                end
                PAUSE: begin
                    if (!pause) begin
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Speed is sampled only at restart and at each tick so periods never change mid-way
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_speed <= '0;
        end else if (w_restart || (w_count_en && w_tick_wrap)) begin
            r_speed <= SPD_W'(clamp_speed(32'(speed), 32'(MAX_SPEED)));
        end
    end

    // Gameplay tick and its half-rate toggle; restart gives an immediate tick
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            tick   <= 1'b0;
            duty50 <= 1'b0;
        end else if (w_restart) begin
            tick   <= 1'b1;
            duty50 <= 1'b0;
        end else begin
            tick <= w_count_en & w_tick_wrap;
            if (w_count_en && w_tick_wrap) begin
                duty50 <= ~duty50;
            end
        end
    end

    // Real-time second pulse and saturating seconds count
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sec_pulse   <= 1'b0;
            elapsed_sec <= '0;
        end else if (w_restart) begin
            sec_pulse   <= 1'b0;
            elapsed_sec <= '0;
        end else begin
            sec_pulse <= w_count_en & w_sec_wrap;
            if (w_count_en && w_sec_wrap && (elapsed_sec != SEC_MAX)) begin
                elapsed_sec <= elapsed_sec + SEC_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_game_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_tick_gen
// Description : Self-checking bench for game_tick_gen (CLK_HZ=16,
//               MAX_SPEED=3, SEC_W=4). A driver applies directed and random
//               stimulus at the falling edge and pushes the reference
//               model's expected outputs; a monitor pops and compares after
//               each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_tick_gen;

    localparam int CLK_HZ    = 16;
    localparam int MAX_SPEED = 3;
    localparam int SEC_W     = 4;
    localparam int SEC_SAT   = (1 << SEC_W) - 1;

    typedef struct packed {
        logic             tick;
        logic             duty50;
        logic             sec_pulse;
        logic [SEC_W-1:0] elapsed;
        logic             running;
    } out_t;

    logic             clk = 1'b0;
    logic             resetN = 1'b0;
    logic             startN = 1'b1;
    logic             pause = 1'b0;
    logic [1:0]       speed = 2'd0;
    logic             tick;
    logic             duty50;
    logic             sec_pulse;
    logic [SEC_W-1:0] elapsed_sec;
    logic             running;
`ifdef GAME_TICK_TIMEOUT_EN
    logic             timeout;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    out_t exp_q[$];

    // Reference model state: "how many active cycles into the current period"
    int m_state   = 0;    // 0 idle, 1 run, 2 paused
    int m_speed   = 0;
    int m_active  = 0;
    int m_sec_act = 0;
    int m_duty    = 0;
    int m_elapsed = 0;

    logic cur_pause = 1'b0;
    logic [1:0] cur_speed = 2'd0;

    game_tick_gen #(
        .CLK_HZ    (CLK_HZ),
        .MAX_SPEED (MAX_SPEED),
        .SEC_W     (SEC_W)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .startN      (startN),
        .pause       (pause),
        .speed       (speed),
        .tick        (tick),
        .duty50      (duty50),
        .sec_pulse   (sec_pulse),
        .elapsed_sec (elapsed_sec),
`ifdef GAME_TICK_TIMEOUT_EN
        .timeout     (timeout),
`endif
        .running     (running)
    );

    always #5 clk = ~clk;

    // Compute what the outputs must be after the coming rising edge
    function automatic out_t model_step(input logic rn, input logic sn,
                                        input logic pz, input int sp);
        out_t e;
        int   period;
        e = '0;
        if (!rn) begin
            m_state = 0; m_speed = 0; m_active = 0; m_sec_act = 0;
            m_duty = 0; m_elapsed = 0;
        end else if (!sn) begin
            m_state = 1; m_active = 0; m_sec_act = 0; m_duty = 0; m_elapsed = 0;
            m_speed = (sp > MAX_SPEED) ? MAX_SPEED : sp;
            e.tick = 1'b1;
        end else if (m_state == 1 && !pz) begin
            period = CLK_HZ / (2 ** m_speed);
            m_active++;
            if (m_active == period) begin
                e.tick   = 1'b1;
                m_active = 0;
                m_duty   = 1 - m_duty;
                m_speed  = (sp > MAX_SPEED) ? MAX_SPEED : sp;
            end
            m_sec_act++;
            if (m_sec_act == CLK_HZ) begin
                e.sec_pulse = 1'b1;
                m_sec_act   = 0;
                if (m_elapsed < SEC_SAT) m_elapsed++;
            end
        end else if (m_state == 1 && pz) begin
            m_state = 2;
        end else if (m_state == 2 && !pz) begin
            m_state = 1;
        end
        e.duty50  = (m_duty != 0);
        e.elapsed = SEC_W'(m_elapsed);
        e.running = (m_state == 1);
        return e;
    endfunction

    // One cycle of stimulus: apply inputs, push expectation, check async reset
    task automatic step(input logic rn, input logic sn, input logic pz,
                        input logic [1:0] sp);
        @(negedge clk);
        resetN = rn; startN = sn; pause = pz; speed = sp;
        exp_q.push_back(model_step(rn, sn, pz, int'(sp)));
        if (!rn) begin
            #1;
            n_checks++;
            if ({tick, duty50, sec_pulse, elapsed_sec, running} != '0) begin
                n_errors++;
                $display("FAIL async_reset t=%0t: got tick=%b duty50=%b sec_pulse=%b elapsed=%0d running=%b, need all 0",
                         $time, tick, duty50, sec_pulse, elapsed_sec, running);
            end
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, cur_pause, cur_speed);
    endtask

    task automatic restart(input logic [1:0] sp);
        cur_speed = sp;
        step(1'b1, 1'b0, cur_pause, sp);
    endtask

    // Monitor: compare every presented output vector against the scoreboard
    always @(posedge clk) begin
        out_t e;
        out_t a;
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {tick, duty50, sec_pulse, elapsed_sec, running};
            n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL outputs cycle=%0d: got tick=%b duty50=%b sec_pulse=%b elapsed=%0d running=%b, need tick=%b duty50=%b sec_pulse=%b elapsed=%0d running=%b",
                         cyc, a.tick, a.duty50, a.sec_pulse, a.elapsed, a.running,
                         e.tick, e.duty50, e.sec_pulse, e.elapsed, e.running);
            end
        end
    end

    initial begin
        // Reset and idle
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 2'd0);
        run_cycles(4);

        // Speed 0: tick and sec_pulse every 16 cycles
        restart(2'd0);
        run_cycles(40);

        // Speed 2, then drop to 0 mid-period
        restart(2'd2);
        run_cycles(6);
        cur_speed = 2'd0;
        run_cycles(40);

        // Highest speed: tick every 2 cycles
        restart(2'd3);
        run_cycles(12);

        // Pause mid-period for 10 cycles, then resume
        restart(2'd0);
        run_cycles(7);
        cur_pause = 1'b1;
        run_cycles(10);
        cur_pause = 1'b0;
        run_cycles(30);

        // Pause landing on a terminal count
        restart(2'd1);
        run_cycles(7);
        cur_pause = 1'b1;
        run_cycles(3);
        cur_pause = 1'b0;
        run_cycles(10);

        // Run 21 seconds: elapsed_sec saturates, then restart
        restart(2'd1);
        run_cycles(21 * CLK_HZ);
        restart(2'd0);
        run_cycles(20);

        // Asynchronous reset mid-run, held low in IDLE, then restart
        step(1'b0, 1'b1, 1'b0, cur_speed);
        step(1'b0, 1'b1, 1'b0, cur_speed);
        run_cycles(3);
        restart(2'd2);
        run_cycles(10);

        // Randomised play: speed changes, pause bursts, restarts, rare resets
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) cur_speed = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) cur_pause = ~cur_pause;
            if ($urandom_range(0, 299) == 0) begin
                step(1'b0, 1'b1, cur_pause, cur_speed);
            end else if ($urandom_range(0, 63) == 0) begin
                step(1'b1, 1'b0, cur_pause, cur_speed);
            end else begin
                step(1'b1, 1'b1, cur_pause, cur_speed);
            end
        end

        // Drain the scoreboard
        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending, need 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
